pipeline_controller: RTL
========================

Name: pipeline_controller

Overview:
- Sequences the 5-stage (F/D/E/M/W) datapath driven by the decode control unit.
- Owns run/halt state, load-use and branch hazard stall/flush generation, E-stage operand forwarding, data-memory wait stalls, and stop-instruction pipeline drain.
- Sits beside the datapath. Consumes stage-register control fields and register addresses; drives stage enables, flushes, forwarding selects and status counters.

Parameters:
- REG_ADDR_W, 4, register-file address width (register 0 is hardwired zero and is never a forwarding or hazard source).
- CNT_W, 32, width of the cycle and retired-instruction counters.
- DRAIN_CYCLES, 3, cycles after a stop leaves D until the W stage is empty.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  begin execution (acted on in IDLE only)
- stop_d  in  1  stop flag of the instruction in D
- rs1_d, rs2_d  in  REG_ADDR_W each  source registers in D
- rs1_e, rs2_e, rd_e  in  REG_ADDR_W each  sources and destination in E
- result_src_e  in  2  result select in E (2'b01 = load)
- pc_src_e  in  1  taken branch/jump resolved in E
- rd_m  in  REG_ADDR_W  destination in M
- reg_write_m  in  1  register write enable in M
- mem_access_m  in  1  load or store in M
- mem_ready  in  1  data memory completes access this cycle
- rd_w  in  REG_ADDR_W  destination in W
- reg_write_w, valid_w  in  1 each  register write enable in W; W holds a real (non-bubble) instruction
- pc_en  out  1  PC update enable
- stall_f, stall_d, stall_e, stall_m  out  1 each  hold stage register
- flush_d, flush_e, flush_w  out  1 each  insert bubble
- forward_a_e, forward_b_e  out  2 each  00 = RF, 01 = W result, 10 = M ALU result
- running, halted  out  1 each  status
- cycle_count, retired_count  out  CNT_W each  performance counters

Behaviour:
- States: IDLE, RUN, MEM_WAIT, DRAIN, HALTED. rst_n=0 at a clock edge -> IDLE, both counters 0, drain counter 0. This holds from any state, including mid-MEM_WAIT or DRAIN.
- IDLE:
  - pc_en=0, stall_f=stall_d=1, flush_e=flush_w=1, all other stall/flush outputs 0, forwards 00, running=0, halted=0.
  - start=1 -> RUN on the next edge.
- lw_stall = (result_src_e==01) & (rd_e!=0) & (rd_e==rs1_d | rd_e==rs2_d).
- RUN:
  - running=1, pc_en = !stall_f.
  - stall_f = stall_d = lw_stall & !pc_src_e.
  - flush_e = lw_stall | pc_src_e; flush_d = pc_src_e. Branch takes priority: the D instruction is squashed, so no load-use stall occurs.
- Forwarding, active in RUN/MEM_WAIT/DRAIN only, otherwise 00. Priority M over W:
  - forward_a_e = 10 if reg_write_m & rd_m!=0 & rd_m==rs1_e;
  - else 01 if reg_write_w & rd_w!=0 & rd_w==rs1_e;
  - else 00.
  - forward_b_e is identical using rs2_e.
- Memory wait, from RUN or DRAIN:
  - mem_access_m & !mem_ready -> all of stall_f..stall_m=1, flush_w=1, pc_en=0, flush_d=flush_e=0. Next state MEM_WAIT.
  - The stall is asserted combinationally in the same cycle the condition appears.
  - In MEM_WAIT the same outputs hold while mem_ready=0.
  - mem_ready=1 -> stalls drop that cycle and the state returns to the state it came from (RUN or DRAIN, remembered in one register). The drain counter is frozen throughout.
- Stop:
  - In RUN, stop_d & !pc_src_e & !lw_stall & no memory wait -> DRAIN, drain counter loaded DRAIN_CYCLES-1.
  - A stop squashed by a taken branch is ignored.
- DRAIN:
  - pc_en=0, stall_f=1, flush_d=1 (no new instructions); E/M/W advance and forwarding stays active.
  - The counter decrements each non-waiting cycle; counter==0 -> HALTED.
- HALTED:
  - pc_en=0, stall_f=stall_d=1, flush_e=flush_w=1, halted=1, running=0.
  - Sticky until reset; start is ignored.
- Counters:
  - cycle_count increments every cycle in RUN/MEM_WAIT/DRAIN.
  - retired_count increments when valid_w=1 and flush_w=0.
  - Both saturate at all-ones.
  - Both are registered; the value is visible the cycle after the event.

Decomposition:
- Package pipe_ctrl_pkg: state enum; fwd_sel_t {FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10}; RESSRC_MEM=2'b01; OP_STOP=4'b1101.
- Sub-module forwarding_unit: combinational M/W-to-E select logic, instantiated once per source operand.

Test Plan:
- Reset then start=1 for one cycle -> next cycle running=1, pc_en=1; cycle_count=1 one cycle later.
- Load r3 in E (result_src_e=01, rd_e=3) with rs2_d=3 -> stall_f=stall_d=flush_e=1 for exactly one cycle. With rd_e=0 -> no stall.
- pc_src_e=1 together with the load-use condition -> flush_d=flush_e=1, stall_f=0, pc_en=1.
- reg_write_m=1, rd_m=5 and reg_write_w=1, rd_w=5, rs1_e=5 -> forward_a_e=10. Drop reg_write_m -> 01. rd=0 -> 00.
- mem_access_m=1, mem_ready=0 for 4 cycles, then 1 -> all stalls high for 4 cycles, low in the 5th; cycle_count advances 5.
- stop_d=1 in RUN -> 3 DRAIN cycles with pc_en=0, then halted=1. Inject a memory wait of 2 cycles during DRAIN -> halt is delayed by exactly 2 cycles. rst_n=0 in HALTED -> IDLE with counters 0.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and encodings for the 5-stage pipeline controller.
package pipe_ctrl_pkg;

    typedef enum logic [2:0] {
        PS_IDLE,
        PS_RUN,
        PS_MEM_WAIT,
        PS_DRAIN,
        PS_HALTED
    } pipe_state_t;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_t;

    localparam logic [1:0] RESSRC_MEM = 2'b01;
    localparam logic [3:0] OP_STOP    = 4'b1101;

endpackage

// File: rtl/forwarding_unit.sv
// Selects the E-stage operand source for one register operand; M-stage results win over W.
module forwarding_unit
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = 4
) (
    input  logic                  enable,
    input  logic [REG_ADDR_W-1:0] rsE,
    input  logic [REG_ADDR_W-1:0] rdM,
    input  logic                  regWriteM,
    input  logic [REG_ADDR_W-1:0] rdW,
    input  logic                  regWriteW,
    output fwd_sel_t              fwdSel
);

    always_comb begin
        fwdSel = FWD_RF;
        if (enable) begin
            // Register 0 reads as zero, so a write to it is never a real producer.
            if (regWriteM && (rdM != '0) && (rdM == rsE)) begin
                fwdSel = FWD_MEM;
            end else if (regWriteW && (rdW != '0) && (rdW == rsE)) begin
                fwdSel = FWD_WB;
            end
        end
    end

endmodule

// File: rtl/pipeline_controller.sv
// Run/halt sequencing, hazard stall/flush, forwarding selects and performance counters
// for the F/D/E/M/W datapath.
module pipeline_controller
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W   = 4,
    parameter int CNT_W        = 32,
    parameter int DRAIN_CYCLES = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  stop_d,
    input  logic [REG_ADDR_W-1:0] rs1_d,
    input  logic [REG_ADDR_W-1:0] rs2_d,
    input  logic [REG_ADDR_W-1:0] rs1_e,
    input  logic [REG_ADDR_W-1:0] rs2_e,
    input  logic [REG_ADDR_W-1:0] rd_e,
    input  logic [1:0]            result_src_e,
    input  logic                  pc_src_e,
    input  logic [REG_ADDR_W-1:0] rd_m,
    input  logic                  reg_write_m,
    input  logic                  mem_access_m,
    input  logic                  mem_ready,
    input  logic [REG_ADDR_W-1:0] rd_w,
    input  logic                  reg_write_w,
    input  logic                  valid_w,
    output logic                  pc_en,
    output logic                  stall_f,
    output logic                  stall_d,
    output logic                  stall_e,
    output logic                  stall_m,
    output logic                  flush_d,
    output logic                  flush_e,
    output logic                  flush_w,
    output logic [1:0]            forward_a_e,
    output logic [1:0]            forward_b_e,
    output logic                  running,
    output logic                  halted,
    output logic [CNT_W-1:0]      cycle_count,
    output logic [CNT_W-1:0]      retired_count
);

    localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES + 1) : 1;
    localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(DRAIN_CYCLES - 1);

    pipe_state_t         state, stateNext;
    pipe_state_t         resumeState, resumeStateNext;
    pipe_state_t         activeState;
    logic [DRAIN_W-1:0]  drainCnt, drainCntNext;
    logic                loadUseStall;
    logic                waiting;
    logic                isActive;
    logic                holdFetch;
    logic [CNT_W-1:0]    cycleCnt, retiredCnt;
    fwd_sel_t            fwdA, fwdB;

    function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] value);
        return (&value) ? value : value + CNT_W'(1);
    endfunction

    always_comb begin
        loadUseStall = (result_src_e == RESSRC_MEM) && (rd_e != '0) &&
                       ((rd_e == rs1_d) || (rd_e == rs2_d));
        isActive     = (state == PS_RUN) || (state == PS_MEM_WAIT) || (state == PS_DRAIN);
        // Once in MEM_WAIT only mem_ready matters; the release cycle behaves like the resumed state.
        if (state == PS_MEM_WAIT) begin
            waiting     = !mem_ready;
            activeState = resumeState;
        end else begin
            waiting     = isActive && mem_access_m && !mem_ready;
            activeState = state;
        end
    end

    always_comb begin
        stateNext       = state;
        resumeStateNext = resumeState;
        drainCntNext    = drainCnt;
        holdFetch       = 1'b0;
        pc_en           = 1'b0;
        stall_f         = 1'b0;
        stall_d         = 1'b0;
        stall_e         = 1'b0;
        stall_m         = 1'b0;
        flush_d         = 1'b0;
        flush_e         = 1'b0;
        flush_w         = 1'b0;
        running         = 1'b0;
        halted          = 1'b0;

        case (state)
            PS_IDLE: begin
                stall_f = 1'b1;
                stall_d = 1'b1;
                flush_e = 1'b1;
                flush_w = 1'b1;
                if (start) stateNext = PS_RUN;
            end
            PS_HALTED: begin
                stall_f = 1'b1;
                stall_d = 1'b1;
                flush_e = 1'b1;
                flush_w = 1'b1;
                halted  = 1'b1;
            end
            default: begin
                running = 1'b1;
                if (waiting) begin
                    stall_f = 1'b1;
                    stall_d = 1'b1;
                    stall_e = 1'b1;
                    stall_m = 1'b1;
                    flush_w = 1'b1;
                    if (state != PS_MEM_WAIT) begin
                        stateNext       = PS_MEM_WAIT;
                        resumeStateNext = state;
                    end
                end else if (activeState == PS_RUN) begin
                    // A taken branch squashes D, which removes the load-use hazard with it.
                    holdFetch = loadUseStall && !pc_src_e;
                    stall_f   = holdFetch;
                    stall_d   = holdFetch;
                    pc_en     = !holdFetch;
                    flush_e   = loadUseStall || pc_src_e;
                    flush_d   = pc_src_e;
                    stateNext = PS_RUN;
                    if (stop_d && !pc_src_e && !loadUseStall) begin
                        stateNext    = PS_DRAIN;
                        drainCntNext = DRAIN_LOAD;
                    end
                end else begin
                    stall_f = 1'b1;
                    flush_d = 1'b1;
                    if (drainCnt == '0) begin
                        stateNext = PS_HALTED;
                    end else begin
                        stateNext    = PS_DRAIN;
                        drainCntNext = drainCnt - DRAIN_W'(1);
                    end
                end
            end
        endcase
    end

    forwarding_unit #(.REG_ADDR_W(REG_ADDR_W)) uFwdA (
        .enable    (isActive),
        .rsE       (rs1_e),
        .rdM       (rd_m),
        .regWriteM (reg_write_m),
        .rdW       (rd_w),
        .regWriteW (reg_write_w),
        .fwdSel    (fwdA)
    );

    forwarding_unit #(.REG_ADDR_W(REG_ADDR_W)) uFwdB (
        .enable    (isActive),
        .rsE       (rs2_e),
        .rdM       (rd_m),
        .regWriteM (reg_write_m),
        .rdW       (rd_w),
        .regWriteW (reg_write_w),
        .fwdSel    (fwdB)
    );

    assign forward_a_e   = fwdA;
    assign forward_b_e   = fwdB;
    assign cycle_count   = cycleCnt;
    assign retired_count = retiredCnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= PS_IDLE;
            resumeState <= PS_RUN;
            drainCnt    <= '0;
            cycleCnt    <= '0;
            retiredCnt  <= '0;
        end else begin
            state       <= stateNext;
            resumeState <= resumeStateNext;
            drainCnt    <= drainCntNext;
            if (isActive) cycleCnt <= satInc(cycleCnt);
            if (valid_w && !flush_w) retiredCnt <= satInc(retiredCnt);
        end
    end

endmodule
